// File: rtl/strum_judge_pkg.sv
// Shared constants, FSM encoding and multiplier helper for the strum judge and game-side blocks.
package strum_judge_pkg;

    localparam int unsigned NLANES          = 4;
    localparam int unsigned DEBOUNCE_CYCLES = 16;
    localparam int unsigned WINDOW_TICKS    = 2;
    localparam int unsigned HIT_POINTS      = 10;
    localparam int unsigned COMBO_STEP      = 10;
    localparam int unsigned MAX_MULT        = 4;
    localparam int unsigned SCORE_W         = 32;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StResolved
    } state_e;

    // Multiplier for a given combo: 1 + min(combo / COMBO_STEP, MAX_MULT - 1).
    function automatic logic [2:0] mult_of(input logic [7:0] combo);
        int unsigned steps;
        steps = 32'(combo) / COMBO_STEP;
        if (steps > MAX_MULT - 1) begin
            steps = MAX_MULT - 1;
        end
        return 3'(steps + 1);
    endfunction

endpackage

// File: rtl/strum_judge_if.sv
// Player-input and scoring signals between the game side (master) and the judge (slave).
interface strum_judge_if;
    import strum_judge_pkg::*;

    logic                gameclk;
    logic                strum;
    logic [NLANES-1:0]   buttons;
    logic [NLANES-1:0]   intersections;
    logic                hit;
    logic                miss;
    logic [7:0]          combo;
    logic [2:0]          multiplier;
    logic [SCORE_W-1:0]  score;

    modport master (
        output gameclk, strum, buttons, intersections,
        input  hit, miss, combo, multiplier, score
    );

    modport slave (
        input  gameclk, strum, buttons, intersections,
        output hit, miss, combo, multiplier, score
    );

endinterface

// File: rtl/strum_judge_sync_debounce.sv
// 2-FF synchronizer, stability counter and rising-edge pulse for one asynchronous input.
module strum_judge_sync_debounce #(
    parameter int unsigned Cycles = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;

    logic            meta_q, sync_q;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Level flips on the Cycles-th consecutive sample that disagrees with it.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CntW'(Cycles - 1)) begin
                level_d = sync_q;
                rise_d  = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounce state and registered edge pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= async_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/strum_judge.sv
// Hit judging FSM, judgement window and combo/multiplier/score datapath for the guitar game.
module strum_judge
    import strum_judge_pkg::*;
#(
    parameter int unsigned DebounceCycles = DEBOUNCE_CYCLES,
    parameter int unsigned WindowTicks    = WINDOW_TICKS
) (
    input  logic          clock,
    input  logic          reset,
    strum_judge_if.slave  bus
);

    localparam int unsigned WinW = $clog2(WindowTicks + 1);

    logic               strum_ev, tick;
    state_e             state_q, state_d;
    logic [WinW-1:0]    win_q, win_d;
    logic [NLANES-1:0]  pending_q, pending_d;
    logic               judge_hit, judge_miss, close, load;
    logic               hit_q, hit_d, miss_q, miss_d;
    logic [7:0]         combo_q, combo_d;
    logic [2:0]         mult_q, mult_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   sum;

    strum_judge_sync_debounce #(.Cycles(DebounceCycles)) u_strum (
        .clk_i   (clock),
        .rst_i   (reset),
        .async_i (bus.strum),
        .rise_o  (strum_ev)
    );

    strum_judge_sync_debounce #(.Cycles(1)) u_gameclk (
        .clk_i   (clock),
        .rst_i   (reset),
        .async_i (bus.gameclk),
        .rise_o  (tick)
    );

    // Next state, window countdown and the hit/miss judgement for this cycle.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        pending_d  = pending_q;
        judge_hit  = 1'b0;
        judge_miss = 1'b0;
        close      = 1'b0;
        load       = 1'b0;
        unique case (state_q)
            StIdle: begin
                judge_miss = strum_ev;
                load       = tick && (bus.intersections != '0);
            end
            StArmed: begin
                if (strum_ev) begin
                    judge_hit  = (bus.buttons == pending_q);
                    judge_miss = (bus.buttons != pending_q);
                    state_d    = StResolved;
                end
                if (tick) begin
                    win_d = win_q - 1'b1;
                    close = (win_q == WinW'(1));
                    // A strum on the closing tick was already judged; no expiry miss then.
                    if (close && !strum_ev) begin
                        judge_miss = 1'b1;
                    end
                end
            end
            StResolved: begin
                judge_miss = strum_ev;
                if (tick) begin
                    win_d = win_q - 1'b1;
                    close = (win_q == WinW'(1));
                end
            end
            default: state_d = StIdle;
        endcase
        if (close) begin
            state_d = StIdle;
            load    = (bus.intersections != '0);
        end
        if (load) begin
            pending_d = bus.intersections;
            win_d     = WinW'(WindowTicks);
            state_d   = StArmed;
        end
    end

    // Scoring: score uses the multiplier in force before this hit.
    always_comb begin
        hit_d   = judge_hit;
        miss_d  = judge_miss;
        combo_d = combo_q;
        mult_d  = mult_q;
        score_d = score_q;
        sum     = {1'b0, score_q} + (SCORE_W + 1)'(HIT_POINTS * 32'(mult_q));
        if (judge_hit) begin
            combo_d = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
            mult_d  = mult_of(combo_d);
            score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        end else if (judge_miss) begin
            combo_d = 8'd0;
            mult_d  = 3'd1;
        end
    end

    // FSM and window registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            win_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            pending_q <= pending_d;
        end
    end

    // Registered judgement pulses and scoring state.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            combo_q <= 8'd0;
            mult_q  <= 3'd1;
            score_q <= '0;
        end else begin
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            combo_q <= combo_d;
            mult_q  <= mult_d;
            score_q <= score_d;
        end
    end

    assign bus.hit        = hit_q;
    assign bus.miss       = miss_q;
    assign bus.combo      = combo_q;
    assign bus.multiplier = mult_q;
    assign bus.score      = score_q;

endmodule
